// File: rtl/queue_pkg.sv
// Shared types for the queue burst reader: FSM state encoding and skid depth.
package queue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } burst_state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid stage. inREQ comes straight from a flop, so there is no
// combinational path from either handshake back to the upstream ready.
module skid_buffer
  import queue_pkg::*;
#(
  parameter int BitWidth = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inACK,
  output logic                inREQ,
  input  logic [BitWidth-1:0] dIN,
  output logic                outACK,
  input  logic                outREQ,
  output logic [BitWidth-1:0] dOUT
);

  logic [BitWidth-1:0] r_mem [SKID_DEPTH];
  logic                r_wrPtr;
  logic                r_rdPtr;
  logic [1:0]          r_count;
  logic                r_inReq;

  logic                w_push;
  logic                w_pop;
  logic [1:0]          w_nextCount;

  assign w_push = inACK && r_inReq;
  assign w_pop  = outREQ && (r_count != 2'd0);

  assign inREQ  = r_inReq;
  assign outACK = (r_count != 2'd0);
  assign dOUT   = r_mem[r_rdPtr];

  always_comb begin
    w_nextCount = r_count;
    if (w_push && !w_pop) begin
      w_nextCount = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_nextCount = r_count - 2'd1;
    end
  end

  // Ready for the next cycle is decided now from the occupancy we are about to hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
      r_inReq <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= dIN;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= w_nextCount;
      r_inReq <= (w_nextCount != 2'(SKID_DEPTH));
    end
  end

endmodule

// File: rtl/queue_burst_reader.sv
// Pulls a commanded number of words from an upstream queue and forwards them
// through a skid stage, flagging the final word and pulsing BurstDone afterwards.
module queue_burst_reader
  import queue_pkg::*;
#(
  parameter int BitWidth = 32,
  parameter int LenWidth = 8
) (
  input  logic                clk,
  input  logic                rst,
  output logic                cmdREQ,
  input  logic                cmdACK,
  input  logic [LenWidth-1:0] cmdLen,
  output logic                qREQ,
  input  logic                qACK,
  input  logic [BitWidth-1:0] qDIN,
  output logic                dOutACK,
  input  logic                dOutREQ,
  output logic [BitWidth-1:0] dOUT,
  output logic                dOutLast,
  output logic                Busy,
  output logic                BurstDone,
  output logic [LenWidth-1:0] WordsLeft
);

  burst_state_t        r_state;
  logic [LenWidth-1:0] r_pullLeft;
  logic [LenWidth-1:0] r_wordsLeft;

  logic                w_skidInReq;
  logic                w_push;
  logic                w_pop;

  assign qREQ      = (r_state == PULL) && (r_pullLeft != '0) && w_skidInReq;
  assign w_push    = qREQ && qACK;
  assign w_pop     = dOutACK && dOutREQ;

  assign cmdREQ    = (r_state == IDLE);
  assign Busy      = (r_state != IDLE);
  assign BurstDone = (r_state == DONE);
  assign dOutLast  = dOutACK && (r_wordsLeft == LenWidth'(1));
  assign WordsLeft = r_wordsLeft;

  skid_buffer #(
    .BitWidth(BitWidth)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .inACK  (w_push),
    .inREQ  (w_skidInReq),
    .dIN    (qDIN),
    .outACK (dOutACK),
    .outREQ (dOutREQ),
    .dOUT   (dOUT)
  );

  // Counter decrements come first so a command load in IDLE takes precedence.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pullLeft  <= '0;
      r_wordsLeft <= '0;
    end else begin
      if (w_push) begin
        r_pullLeft <= r_pullLeft - LenWidth'(1);
      end
      if (w_pop) begin
        r_wordsLeft <= r_wordsLeft - LenWidth'(1);
      end

      case (r_state)
        IDLE: begin
          if (cmdACK) begin
            if (cmdLen != '0) begin
              r_state     <= PULL;
              r_pullLeft  <= cmdLen;
              r_wordsLeft <= cmdLen;
            end else begin
              r_state <= DONE;
            end
          end
        end
        PULL: begin
          if (w_push && (r_pullLeft == LenWidth'(1))) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_pop && (r_wordsLeft == LenWidth'(1))) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
